// File: rtl/multi_collision_resolver_pkg.sv
// Shared types and constants for the multi-entity collision resolver:
// FSM encoding, probe direction indices, entity state field positions.
package multi_collision_resolver_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SNAP  = 3'd1,
        S_SCAN  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int X_MSB = 31;
    localparam int X_LSB = 22;
    localparam int Y_MSB = 21;
    localparam int Y_LSB = 12;

    localparam int COORD_W = 10;
    localparam int PIDX_W  = 5;   // up to 8 entities x 4 directions

    // One in-flight level read awaiting its blockType result
    typedef struct packed {
        logic              vld;
        logic              oob;
        logic [PIDX_W-1:0] idx;
    } cap_t;

endpackage

// File: rtl/multi_collision_resolver_probe_addr_gen.sv
// Combinational probe address generator: entity origin + direction ->
// probe coordinate, with out-of-bounds detection in 11-bit arithmetic.
module probe_addr_gen
    import multi_collision_resolver_pkg::*;
#(
    parameter int ENT_W = 16,
    parameter int ENT_H = 16,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480
) (
    input  logic [COORD_W-1:0] ent_x,
    input  logic [COORD_W-1:0] ent_y,
    input  dir_t               dir,
    output logic [COORD_W-1:0] probe_x,
    output logic [COORD_W-1:0] probe_y,
    output logic               oob
);

    logic [COORD_W:0] px;
    logic [COORD_W:0] py;

    always_comb begin
        px = {1'b0, ent_x};
        py = {1'b0, ent_y};
        case (dir)
            DIR_DOWN: begin
                px = {1'b0, ent_x} + 11'(ENT_W / 2);
                py = {1'b0, ent_y} + 11'(ENT_H);
            end
            DIR_UP: begin
                px = {1'b0, ent_x} + 11'(ENT_W / 2);
                py = {1'b0, ent_y} - 11'd1;
            end
            DIR_LEFT: begin
                px = {1'b0, ent_x} - 11'd1;
                py = {1'b0, ent_y} + 11'(ENT_H / 2);
            end
            DIR_RIGHT: begin
                px = {1'b0, ent_x} + 11'(ENT_W);
                py = {1'b0, ent_y} + 11'(ENT_H / 2);
            end
        endcase
        // MSB set means the subtraction wrapped below zero (or ran past 1023)
        oob     = px[COORD_W] | py[COORD_W] | (px >= 11'(SCR_W)) | (py >= 11'(SCR_H));
        probe_x = oob ? '0 : px[COORD_W-1:0];
        probe_y = oob ? '0 : py[COORD_W-1:0];
    end

endmodule

// File: rtl/multi_collision_resolver.sv
// Multi-entity collision resolver: snapshots N_ENT entity states on a sim tick,
// probes four edge points per entity through one level read port, publishes flags.
// Optional per-entity scan enable via macro COLLISION_MASK_EN.
module multi_collision_resolver
    import multi_collision_resolver_pkg::*;
#(
    parameter int N_ENT = 4,
    parameter int ENT_W = 16,
    parameter int ENT_H = 16,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sim_clk,
    input  logic [N_ENT*32-1:0]  ent_state,
`ifdef COLLISION_MASK_EN
    input  logic [N_ENT-1:0]     ent_mask,
`endif
    output logic [COORD_W-1:0]   x,
    output logic [COORD_W-1:0]   y,
    input  logic                 blockType,
    output logic [N_ENT*4-1:0]   col,
    output logic                 col_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [PIDX_W-1:0] LAST_PROBE = PIDX_W'(4 * N_ENT - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic                     scanning;

    logic [N_ENT-1:0][31:0]   ent_shadow;
    logic [N_ENT-1:0]         ent_en;
    logic [PIDX_W-1:0]        pidx;
    cap_t                     cap;
    logic [N_ENT*4-1:0]       work;
    logic [N_ENT*4-1:0]       work_nxt;
    logic [N_ENT*4-1:0]       en_bits;
    logic [COORD_W-1:0]       x_hold;
    logic [COORD_W-1:0]       y_hold;

    logic [31:0]              cur_ent;
    logic [COORD_W-1:0]       probe_x;
    logic [COORD_W-1:0]       probe_y;
    logic                     probe_oob;
    logic                     unused_fields;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sim_clk) state_nxt = S_SNAP;
            S_SNAP:  state_nxt = S_SCAN;
            S_SCAN:  if (pidx == LAST_PROBE) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy      = (state != S_IDLE);
        col_valid = (state == S_DONE);
        scanning  = (state == S_SCAN);
    end

    always_comb begin
        cur_ent = '0;
        for (int i = 0; i < N_ENT; i++)
            if (pidx[PIDX_W-1:2] == 3'(i)) cur_ent = ent_shadow[i];
    end

    probe_addr_gen #(
        .ENT_W (ENT_W),
        .ENT_H (ENT_H),
        .SCR_W (SCR_W),
        .SCR_H (SCR_H)
    ) u_probe (
        .ent_x   (cur_ent[X_MSB:X_LSB]),
        .ent_y   (cur_ent[Y_MSB:Y_LSB]),
        .dir     (dir_t'(pidx[1:0])),
        .probe_x (probe_x),
        .probe_y (probe_y),
        .oob     (probe_oob)
    );

    assign x = scanning ? probe_x : x_hold;
    assign y = scanning ? probe_y : y_hold;

    // Out-of-bounds probes never consult blockType
    always_comb begin
        work_nxt = work;
        for (int i = 0; i < N_ENT * 4; i++)
            if (cap.vld && cap.idx == PIDX_W'(i)) work_nxt[i] = cap.oob | blockType;
    end

    always_comb begin
        for (int i = 0; i < N_ENT; i++) en_bits[4*i +: 4] = {4{ent_en[i]}};
    end

    always_comb begin
        unused_fields = 1'b0;
        for (int i = 0; i < N_ENT; i++)
            unused_fields = unused_fields ^ (^ent_shadow[i][Y_LSB-1:0]);
    end

`ifdef COLLISION_MASK_EN
    always_ff @(posedge clk) begin
        if (reset)                 ent_en <= '0;
        else if (state == S_SNAP)  ent_en <= ent_mask;
    end
`else
    assign ent_en = '1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_shadow <= '0;
            pidx       <= '0;
            cap        <= '0;
            work       <= '0;
            col        <= '0;
            overrun    <= 1'b0;
            x_hold     <= '0;
            y_hold     <= '0;
        end else begin
            if (sim_clk && state != S_IDLE) overrun <= 1'b1;
            if (state == S_SNAP) begin
                ent_shadow <= ent_state;
                pidx       <= '0;
            end
            if (scanning) begin
                pidx   <= pidx + 1'b1;
                x_hold <= probe_x;
                y_hold <= probe_y;
            end
            cap.vld <= scanning;
            cap.oob <= probe_oob;
            cap.idx <= pidx;
            work    <= work_nxt;
            // Whole-vector publish lands on entry to DONE, alongside col_valid
            if (state == S_FLUSH) col <= work_nxt & en_bits;
        end
    end

endmodule

// File: tb/tb_multi_collision_resolver.sv
// Directed-vector bench for multi_collision_resolver (N_ENT=4, 640x480 field).
module tb_multi_collision_resolver;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         sim_clk = 1'b0;
    logic [127:0] ent_state = '0;
    logic [9:0]   x, y;
    logic         blockType = 1'b0;
    logic [15:0]  col;
    logic         col_valid, busy, overrun;
`ifdef COLLISION_MASK_EN
    logic [3:0]   ent_mask = 4'b1111;
`endif

    int vectors = 0;
    int miscompares = 0;
    int level_mode = 0;

    int          lat;
    int          pulses;
    logic [9:0]  xs [0:40];
    logic [9:0]  ys [0:40];
    logic        bz [0:40];
    logic [15:0] col_mid;

    multi_collision_resolver dut (
        .clk       (clk),
        .reset     (reset),
        .sim_clk   (sim_clk),
        .ent_state (ent_state),
`ifdef COLLISION_MASK_EN
        .ent_mask  (ent_mask),
`endif
        .x         (x),
        .y         (y),
        .blockType (blockType),
        .col       (col),
        .col_valid (col_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Level model: registered read, result visible the cycle after the address
    function automatic logic solid(input logic [9:0] px, input logic [9:0] py);
        case (level_mode)
            1:       return py == 10'd216;
            2:       return py == 10'd116;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) blockType <= solid(x, y);

    function automatic logic [31:0] ent(input int ex, input int ey);
        return {10'(ex), 10'(ey), 12'h000};
    endfunction

    function automatic logic [127:0] world(input int ex, input int ey);
        return {ent(200, 50), ent(400, 300), ent(300, 100), ent(ex, ey)};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts a scan in cycle 0 and traces 40 further cycles
    task automatic run_scan(input int pulse2, input int chg_cyc, input logic [127:0] chg_val);
        lat = -1;
        pulses = 0;
        sim_clk = 1'b1;
        @(negedge clk);
        sim_clk = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            sim_clk = (c == pulse2);
            if (c == chg_cyc) ent_state = chg_val;
            xs[c] = x;
            ys[c] = y;
            bz[c] = busy;
            if (c == 10) col_mid = col;
            if (col_valid) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            @(negedge clk);
        end
        sim_clk = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++; if (col !== 16'h0) begin miscompares++; $display("FAIL reset_col got %h want 0000", col); end
        vectors++; if ({col_valid, busy, overrun} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {col_valid, busy, overrun}); end
        vectors++; if ({x, y} !== 20'h0) begin miscompares++; $display("FAIL reset_xy got %0d,%0d want 0,0", x, y); end
    endtask

    task automatic test_basic();
        level_mode = 1;
        ent_state = world(100, 200);
        run_scan(0, 0, '0);
        vectors++; if (lat !== 19) begin miscompares++; $display("FAIL basic_latency got %0d want 19", lat); end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL basic_pulses got %0d want 1", pulses); end
        vectors++; if (col !== 16'h0001) begin miscompares++; $display("FAIL basic_col got %h want 0001", col); end
        vectors++; if (xs[2] !== 10'd108 || ys[2] !== 10'd216) begin miscompares++; $display("FAIL basic_down_addr got %0d,%0d want 108,216", xs[2], ys[2]); end
        vectors++; if (bz[1] !== 1'b1 || bz[20] !== 1'b0) begin miscompares++; $display("FAIL basic_busy got %b%b want 10", bz[1], bz[20]); end
    endtask

    task automatic test_bounds();
        level_mode = 0;
        ent_state = world(0, 0);
        run_scan(0, 0, '0);
        vectors++; if (col !== 16'h0006) begin miscompares++; $display("FAIL topleft_col got %h want 0006", col); end
        vectors++; if (xs[3] !== 10'd0 || ys[3] !== 10'd0) begin miscompares++; $display("FAIL topleft_up_addr got %0d,%0d want 0,0", xs[3], ys[3]); end
        vectors++; if (xs[4] !== 10'd0 || ys[4] !== 10'd0) begin miscompares++; $display("FAIL topleft_left_addr got %0d,%0d want 0,0", xs[4], ys[4]); end
        vectors++; if (xs[5] !== 10'd16 || ys[5] !== 10'd8) begin miscompares++; $display("FAIL topleft_right_addr got %0d,%0d want 16,8", xs[5], ys[5]); end
        vectors++; if (xs[6] !== 10'd308 || ys[6] !== 10'd116) begin miscompares++; $display("FAIL ent1_down_addr got %0d,%0d want 308,116", xs[6], ys[6]); end
        vectors++; if (xs[18] !== 10'd216 || ys[18] !== 10'd58) begin miscompares++; $display("FAIL xy_hold got %0d,%0d want 216,58", xs[18], ys[18]); end

        ent_state = world(624, 464);
        run_scan(0, 0, '0);
        vectors++; if (col !== 16'h0009) begin miscompares++; $display("FAIL botright_col got %h want 0009", col); end
        vectors++; if (xs[3] !== 10'd632 || ys[3] !== 10'd463) begin miscompares++; $display("FAIL botright_up_addr got %0d,%0d want 632,463", xs[3], ys[3]); end

        ent_state = world(623, 463);
        run_scan(0, 0, '0);
        vectors++; if (col !== 16'h0000) begin miscompares++; $display("FAIL edge_inside_col got %h want 0000", col); end
        vectors++; if (xs[5] !== 10'd639 || ys[2] !== 10'd479) begin miscompares++; $display("FAIL edge_inside_addr got x%0d y%0d want x639 y479", xs[5], ys[2]); end
    endtask

    task automatic test_back_to_back();
        level_mode = 1;
        ent_state = world(100, 200);
        run_scan(0, 0, '0);
        level_mode = 0;
        ent_state = world(0, 0);
        run_scan(0, 0, '0);
        vectors++; if (col_mid !== 16'h0001) begin miscompares++; $display("FAIL col_hold_midscan got %h want 0001", col_mid); end
        vectors++; if (col !== 16'h0006) begin miscompares++; $display("FAIL b2b_col got %h want 0006", col); end
    endtask

    task automatic test_snapshot();
        level_mode = 1;
        ent_state = world(100, 200);
        run_scan(0, 2, world(0, 0));
        vectors++; if (col !== 16'h0001) begin miscompares++; $display("FAIL snapshot_col got %h want 0001", col); end
    endtask

    task automatic test_overrun();
        do_reset();
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_clear got %b want 0", overrun); end
        level_mode = 1;
        ent_state = world(100, 200);
        run_scan(5, 0, '0);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set got %b want 1", overrun); end
        vectors++; if (pulses !== 1 || lat !== 19) begin miscompares++; $display("FAIL overrun_scan got pulses %0d lat %0d want 1 19", pulses, lat); end
        vectors++; if (col !== 16'h0001) begin miscompares++; $display("FAIL overrun_col got %h want 0001", col); end
    endtask

    task automatic test_done_overrun();
        do_reset();
        run_scan(19, 0, '0);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL done_overrun got %b want 1", overrun); end
        vectors++; if (bz[20] !== 1'b0 || pulses !== 1) begin miscompares++; $display("FAIL done_no_rescan got busy %b pulses %0d want 0 1", bz[20], pulses); end
    endtask

    task automatic test_reset_abort();
        int seen;
        level_mode = 0;
        ent_state = world(0, 0);
        run_scan(0, 0, '0);
        sim_clk = 1'b1;
        @(negedge clk);
        sim_clk = 1'b0;
        for (int c = 1; c < 8; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++; if ({col_valid, busy, overrun} !== 3'b000 || col !== 16'h0) begin miscompares++; $display("FAIL abort_state got cv%b busy%b ovr%b col%h want 0 0 0 0000", col_valid, busy, overrun, col); end
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (col_valid) seen++;
            @(negedge clk);
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_valid got %0d want 0", seen); end
        level_mode = 1;
        ent_state = world(100, 200);
        run_scan(0, 0, '0);
        vectors++; if (lat !== 19 || col !== 16'h0001) begin miscompares++; $display("FAIL abort_rescan got lat %0d col %h want 19 0001", lat, col); end
    endtask

`ifdef COLLISION_MASK_EN
    task automatic test_mask();
        level_mode = 2;
        ent_state = world(100, 100);
        ent_mask = 4'b1101;
        run_scan(0, 0, '0);
        vectors++; if (lat !== 19) begin miscompares++; $display("FAIL mask_latency got %0d want 19", lat); end
        vectors++; if (col !== 16'h0001) begin miscompares++; $display("FAIL mask_col got %h want 0001", col); end
        ent_mask = 4'b1111;
        run_scan(0, 0, '0);
        vectors++; if (col !== 16'h0011) begin miscompares++; $display("FAIL unmask_col got %h want 0011", col); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_bounds();
        test_back_to_back();
        test_snapshot();
        test_overrun();
        test_done_overrun();
        test_reset_abort();
`ifdef COLLISION_MASK_EN
        test_mask();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_collision_resolver.md
MULTI_COLLISION_RESOLVER -- requirements
Module: multi_collision_resolver

Interface
REQ-001 Parameter N_ENT, default 4, number of entities scanned per sim tick (1..8).
REQ-002 Parameter ENT_W, default 16, entity sprite width in pixels.
REQ-003 Parameter ENT_H, default 16, entity sprite height in pixels.
REQ-004 Parameter SCR_W, default 640, SCR_H default 480, playfield bounds in pixels.
REQ-005 clk  in  1  system clock; the block has one clock; reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 sim_clk  in  1  one-cycle simulation tick pulse in clk domain; starts a scan.
REQ-008 ent_state  in  N_ENT*32  packed entity states; entity i at [32i+31:32i], x=[31:22], y=[21:12].
REQ-009 ent_mask  in  N_ENT  per-entity scan enable (present only with COLLISION_MASK_EN).
REQ-010 x, y  out  10 each  level probe address.
REQ-011 blockType  in  1  level lookup result for the address presented the previous cycle (1 = solid).
REQ-012 col  out  N_ENT*4  per-entity flags {right,left,up,down} at [4i+3:4i].
REQ-013 col_valid  out  1  one-cycle pulse when col holds a complete new scan.
REQ-014 busy  out  1  high from sim_clk acceptance until col_valid.
REQ-015 overrun  out  1  sticky; set when sim_clk arrives while busy.

Function
REQ-016 States IDLE, SNAP, SCAN, FLUSH, DONE; IDLE->SNAP on sim_clk; SNAP->SCAN; SCAN->FLUSH after last probe issued; FLUSH->DONE; DONE->IDLE.
REQ-017 SNAP latches all ent_state into shadow registers; later ent_state changes do not affect the scan.
REQ-018 Probe order: entity 0..N_ENT-1, per entity down, up, left, right; one probe issued per SCAN cycle.
REQ-019 Probe points: down (x+ENT_W/2, y+ENT_H); up (x+ENT_W/2, y-1); left (x-1, y+ENT_H/2); right (x+ENT_W, y+ENT_H/2).
REQ-020 Probe arithmetic in 11 bits; any coordinate <0 or >= SCR_W/SCR_H is out of bounds, flagged solid with no dependence on blockType, and x/y driven 0 that cycle.
REQ-021 blockType is captured one clk after its address was driven; capture pipeline carries probe index and out-of-bounds bit.
REQ-022 col is updated only in DONE (whole-vector write); col holds its previous value during a scan.
REQ-023 col_valid asserts exactly in DONE; latency sim_clk to col_valid = 4*N_ENT + 3 clk cycles.
REQ-024 sim_clk while not IDLE is ignored and sets overrun; overrun clears only on reset.
REQ-025 sim_clk in DONE is an overrun, not a new scan.
REQ-026 x, y hold last driven values outside SCAN.

Reset
REQ-027 reset returns FSM to IDLE in the next cycle, aborting any scan with no col_valid pulse.
REQ-028 Reset values: col=0, col_valid=0, busy=0, overrun=0, x=0, y=0, shadows=0.
REQ-029 reset takes priority over sim_clk in the same cycle.

Configuration
REQ-030 Macro COLLISION_MASK_EN: when defined, ent_mask exists, is latched in SNAP, and masked-off entities have col bits forced 0 while their probes still occupy slots (fixed latency).
REQ-031 Without COLLISION_MASK_EN, the ent_mask port is absent and all entities are evaluated.

Structure
REQ-032 Shared package holds state encoding, probe direction indices (DOWN=0, UP=1, LEFT=2, RIGHT=3), and state field bit positions (X_MSB=31, X_LSB=22, Y_MSB=21, Y_LSB=12).
REQ-033 One sub-module, probe_addr_gen: combinational (x, y, direction) -> (probe x, probe y, out-of-bounds).
REQ-034 Block is a drop-in for the single-player collision path: level second read port connects to x, y, blockType.

Verification
REQ-035 N_ENT=4, entity 0 at (100,200), level solid only at y=216 -> after sim_clk, col_valid at cycle 19, col[3:0]=4'b0001, others 0.
REQ-036 Entity at (0,0), empty level -> up and left flags 1 (4'b0110), no read issued for those probes.
REQ-037 Entity at (624,464), empty level -> right and down 1 (4'b1001).
REQ-038 sim_clk again 5 cycles into scan -> overrun=1, single col_valid, latency unchanged.
REQ-039 reset asserted at cycle 8 of scan -> no col_valid, col=0, busy=0 next cycle; next sim_clk scans normally.
REQ-040 COLLISION_MASK_EN, ent_mask=4'b1101, entity 1 on solid floor -> col[7:4]=0, latency still 19.
